subtrator_serial: RTL
=====================

Name: subtrator_serial

Overview:
- Bit-serial two's-complement subtractor. Computes Diff = A - B with signed overflow FLAG, one bit per clock, LSB first.
- Inverse arithmetic companion to the team's combinational somador. Used where area matters more than latency.
- Start/busy/done handshake lets a controller or bench launch one operation at a time.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      launch request; sampled only in IDLE
- A      input   WIDTH  minuend, signed; sampled with start
- B      input   WIDTH  subtrahend, signed; sampled with start
- busy   output  1      high while an operation is in progress
- done   output  1      one-cycle pulse; Diff/FLAG valid from this cycle
- Diff   output  WIDTH  A - B modulo 2^WIDTH, signed
- FLAG   output  1      1 = signed overflow in the last completed operation

Behaviour:
- Reset (rst_n low, asynchronous, overrides everything):
  - state = IDLE; busy = 0; done = 0; Diff = 0; FLAG = 0.
  - Shift registers, bit counter and borrow are cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start = 1 at edge k: latch A and B into shift registers, clear counter and borrow, go to CALC.
  - busy rises after edge k.
- CALC (WIDTH cycles, edges k+1 .. k+WIDTH): each edge processes bit i = counter.
  - d = a_i ^ b_i ^ borrow.
  - borrow' = (~a_i & b_i) | (~(a_i ^ b_i) & borrow).
  - d shifts into the result register from the MSB side. Operand registers shift right. Counter increments.
- At edge k+WIDTH (last bit):
  - Diff is loaded with the completed result.
  - FLAG = (A_msb != B_msb) && (Diff_msb != A_msb), using the latched operands.
  - Go to DONE: busy = 0, done = 1.
- DONE: one cycle only. Next edge returns to IDLE; done = 0.
- Latency: done is high during the cycle after edge k+WIDTH, i.e. WIDTH cycles after start is sampled. New start is accepted at the earliest at the edge ending DONE? No — start is honoured only in IDLE, so the earliest relaunch is the edge after DONE.
- start while busy, or while in DONE: ignored. No queueing, no error.
- A/B changes after the sampling edge have no effect on the running operation.
- Diff and FLAG hold their values until the next completion or reset. They do not change during CALC.
- Final borrow-out is discarded (modulo arithmetic). FLAG reports signed overflow only.
- Reset asserted mid-CALC: the operation is aborted, all outputs go to reset values, and no done pulse is produced.
- start held high continuously: back-to-back operations, one every WIDTH+2 cycles.

Test Plan:
- A=9, B=2, start pulse -> done 8 cycles later; Diff=7 (0x07), FLAG=0; busy high for exactly 8 cycles.
- A=127, B=-17 -> Diff=-112 (0x90), FLAG=1. Also A=-127, B=2 -> Diff=127 (0x7F), FLAG=1.
- A=101, B=111 -> Diff=-10 (0xF6), FLAG=0. A=-128, B=-128 -> Diff=0, FLAG=0.
- Start A=5, B=3; pulse start with A=100, B=1 on cycle 3 while busy -> second start ignored; Diff=2, a single done pulse; Diff holds 2 afterwards.
- Start A=50, B=20; drop rst_n in cycle 4 -> busy, done, Diff, FLAG go to 0 immediately (before the next clock edge); no done pulse. After release, A=50, B=20 -> Diff=30.
- start tied high, A=1, B=1 -> done pulses every 10 cycles; Diff=0, FLAG=0 each time.

Source files
------------

// File: rtl/subtrator_serial.sv
// Bit-serial two's-complement subtractor: Diff = A - B, LSB first, one bit per clock.
// Reports signed overflow on FLAG; start/busy/done handshake, one operation at a time.
module subtrator_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             FLAG
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             borrow, a_msb, b_msb;
  logic             a_i, b_i, d, borrow_nxt, last;

  always_comb begin
    a_i        = a_sh[0];
    b_i        = b_sh[0];
    d          = a_i ^ b_i ^ borrow;
    borrow_nxt = (~a_i & b_i) | (~(a_i ^ b_i) & borrow);
    last       = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      Diff   <= '0;
      FLAG   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh   <= A;
          b_sh   <= B;
          a_msb  <= A[WIDTH-1];
          b_msb  <= B[WIDTH-1];
          res    <= '0;
          cnt    <= '0;
          borrow <= 1'b0;
        end
        CALC: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res    <= {d, res[WIDTH-1:1]};
          borrow <= borrow_nxt;
          cnt    <= cnt + CW'(1);
          // The bit computed on this edge is the result MSB, so it is folded in directly.
          if (last) begin
            Diff <= {d, res[WIDTH-1:1]};
            FLAG <= (a_msb != b_msb) && (d != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
